// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: byte stream -> big-endian words -> sequential writes.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int IDX_W = ADDR_W + 1;

    // Handshake: a byte moves on a rising edge when byte_valid && byte_ready;
    // byte_ready depends on state only, never on byte_valid.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_LOAD  = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK   = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         hdr_hi_q, hdr_hi_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]         phase_q, phase_d;
    logic [23:0]        buf_q, buf_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               accept;
    logic [15:0]        n_hdr;
    logic               oversize;

    assign accept   = byte_valid && byte_ready;
    assign n_hdr    = {hdr_hi_q, byte_in};
    assign oversize = 32'(n_hdr) > (32'd1 << ADDR_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hdr_hi_q   <= '0;
            last_idx_q <= '0;
            word_idx_q <= '0;
            phase_q    <= '0;
            buf_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_hi_q   <= hdr_hi_d;
            last_idx_q <= last_idx_d;
            word_idx_q <= word_idx_d;
            phase_q    <= phase_d;
            buf_q      <= buf_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_hi_d   = hdr_hi_q;
        last_idx_d = last_idx_q;
        word_idx_d = word_idx_q;
        phase_d    = phase_q;
        buf_d      = buf_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_HDR0;
                    word_idx_d = '0;
                    phase_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            S_HDR0: begin
                if (accept) begin
                    hdr_hi_d = byte_in;
                    state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    if (n_hdr == 16'd0) begin
                        state_d = S_DONE;
                    end else if (oversize) begin
                        state_d = S_ERROR;
                    end else begin
                        // N fits the index width here, so N-1 marks the final word.
                        last_idx_d = IDX_W'(n_hdr - 16'd1);
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_in;
`endif
                    phase_d = phase_q + 2'd1;
                    case (phase_q)
                        2'd0: buf_d[23:16] = byte_in;
                        2'd1: buf_d[15:8]  = byte_in;
                        2'd2: buf_d[7:0]   = byte_in;
                        default: begin
                            wr_en_d    = 1'b1;
                            wr_addr_d  = 32'({word_idx_q, 2'b00});
                            wr_data_d  = {buf_q, byte_in};
                            word_idx_d = word_idx_q + 1'b1;
                            if (word_idx_q == last_idx_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = S_CHK;
`else
                                state_d = S_DONE;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (byte_in == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_LOAD: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                  byte_ready = 1'b1;
`endif
            default:                byte_ready = 1'b0;
        endcase
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (ADDR_W=4): random streams against a header/word/checksum model,
// writes checked by a queue-based monitor; honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int CAP    = 1 << ADDR_W;
  localparam int R_DONE = 0;
  localparam int R_ERR  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  stim_q[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && wr_en !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[63:32]);
        check("wr_data", wr_data, e[31:0]);
      end
    end
  end

  // reference model: header -> count, data bytes -> words, XOR over data bytes
  task automatic model(output int res, output int nbytes);
    int         n;
    logic [7:0] cs;
    logic [31:0] w;
    n  = {stim_q[0], stim_q[1]};
    cs = 8'h00;
    if (n == 0) begin
      res = R_DONE;
      nbytes = 2;
    end else if (n > CAP) begin
      res = R_ERR;
      nbytes = 2;
    end else begin
      for (int k = 0; k < n; k++) begin
        w = {stim_q[2+4*k], stim_q[3+4*k], stim_q[4+4*k], stim_q[5+4*k]};
        cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        exp_q.push_back({32'(k * 4), w});
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      res = (stim_q[2+4*n] == cs) ? R_DONE : R_ERR;
      nbytes = 2 + 4 * n + 1;
`else
      res = R_DONE;
      nbytes = 2 + 4 * n;
`endif
    end
  endtask

  task automatic build(input int n, input bit bad);
    logic [7:0] b;
    logic [7:0] cs;
    logic [15:0] n16;
    n16 = 16'(n);
    cs = 8'h00;
    stim_q.delete();
    stim_q.push_back(n16[15:8]);
    stim_q.push_back(n16[7:0]);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      cs = cs ^ b;
      stim_q.push_back(b);
    end
    stim_q.push_back(bad ? (cs ^ 8'h01) : cs);
  endtask

  // driver: called between edges; returns at posedge+1 after acceptance
  task automatic send_byte(input logic [7:0] b);
    int cnt;
    cnt = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (byte_ready !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: got byte_ready %b after %0d cycles, required 1", byte_ready, cnt);
    end else begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wr_en"},      32'(wr_en),      32'd0);
    check({tag, "_wr_addr"},    wr_addr,         32'd0);
    check({tag, "_wr_data"},    wr_data,         32'd0);
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
  endtask

  // one complete load of stim_q; abort_at >= 0 resets the DUT before that byte
  task automatic run_load(input bit gaps, input bit mid_start, input int abort_at);
    int res;
    int nb;
    model(res, nb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ready_after_start", 32'(byte_ready), 32'd1);
    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset_ready", 32'(byte_ready), 32'd0);
        check("idle_after_reset_done", 32'(done), 32'd0);
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        byte_valid = 1'b0;
        byte_in = 8'($urandom_range(0, 255));
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      if (mid_start && nb > 4 && i == nb / 2) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_byte(stim_q[i]);
    end
    check("result_done",   32'(done),       (res == R_DONE) ? 32'd1 : 32'd0);
    check("result_error",  32'(error),      (res == R_ERR)  ? 32'd1 : 32'd0);
    check("result_hold",   32'(cpu_hold),   (res == R_DONE) ? 32'd0 : 32'd1);
    check("result_ready",  32'(byte_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reference stream: two words, checksum 0x45
    stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h01, 8'h09, 8'h40, 8'h20, 8'h45};
    run_load(1'b0, 1'b0, -1);
    stim_q[10] = 8'h44;
    run_load(1'b0, 1'b0, -1);
    stim_q[10] = 8'h45;
    run_load(1'b0, 1'b0, -1);

    // oversize count, then exactly full capacity
    stim_q = '{8'h00, 8'h11, 8'h12, 8'h34};
    run_load(1'b0, 1'b0, -1);
    build(CAP, 1'b0);
    run_load(1'b1, 1'b0, -1);
    stim_q = '{8'h01, 8'h00, 8'h00, 8'h00};
    run_load(1'b0, 1'b0, -1);

    // zero count: no writes, no checksum byte taken
    stim_q = '{8'h00, 8'h00, 8'hAA};
    run_load(1'b0, 1'b0, -1);

    // same image gap-free and with backpressure plus a stray start
    build(5, 1'b0);
    run_load(1'b0, 1'b0, -1);
    run_load(1'b1, 1'b1, -1);

    // random images
    repeat (6) begin
      build($urandom_range(1, CAP), ($urandom_range(0, 3) == 0));
      run_load(1'b1, 1'($urandom_range(0, 1)), -1);
    end

    // reset mid-LOAD, then a clean reload from word 0
    build(8, 1'b0);
    run_load(1'b0, 1'b0, 12);
    run_load(1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
